mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master, one-slave arbiter sharing the single memory port between instruction fetch (IFU) and data access (LSU, driven by the decoder's `dmem_req` / `dmem_wen`) in the multi-cycle NPC core. It accepts one request at a time, forwards it to the memory slave, and routes the response back to the granted master. One transaction is in flight at most; no reordering.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; strobe width is `DATA_W/8`.

Ports:
- `clk` in 1: clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ifu_req_valid` in 1: IFU fetch request.
- `ifu_req_ready` out 1: IFU request accepted this cycle.
- `ifu_req_addr` in ADDR_W: fetch address.
- `ifu_resp_valid` out 1: fetch data valid.
- `ifu_resp_ready` in 1: IFU takes the response.
- `ifu_resp_rdata` out DATA_W: fetched instruction.
- `lsu_req_valid` in 1: LSU load/store request.
- `lsu_req_ready` out 1: LSU request accepted this cycle.
- `lsu_req_addr` in ADDR_W: data address.
- `lsu_req_wen` in 1: 1 = store, 0 = load.
- `lsu_req_wdata` in DATA_W: store data.
- `lsu_req_wstrb` in DATA_W/8: byte enables.
- `lsu_resp_valid` out 1: load data valid, or store acknowledged.
- `lsu_resp_ready` in 1: LSU takes the response.
- `lsu_resp_rdata` out DATA_W: load data. It is 0 for stores.
- `mem_req_valid` out 1: request to the memory slave.
- `mem_req_ready` in 1: slave accepts.
- `mem_req_addr`, `mem_req_wen`, `mem_req_wdata`, `mem_req_wstrb` out: the latched request.
- `mem_resp_valid` in 1: slave response.
- `mem_resp_ready` out 1: arbiter takes the response.
- `mem_resp_rdata` in DATA_W: response data.

## Operation
- FSM states: IDLE, REQ, RESP. The owner register `gnt` is 0 for IFU and 1 for LSU.
- **IDLE:**
  - If any `*_req_valid` is high, pick a winner using the priority rule.
  - Assert that master's `*_req_ready` combinationally in the same cycle.
  - Latch addr, wen, wdata and wstrb into the request registers. IFU requests are latched with wen=0, wdata=0, wstrb=all-ones.
  - Latch `gnt` and go to REQ.
- **REQ:** drive `mem_req_valid`=1 from the registers. On `mem_req_ready`, go to RESP. The registers stay stable while the slave stalls.
- **RESP:**
  - Pass-through: `mem_resp_ready` = the granted master's `*_resp_ready`, and the granted master's `*_resp_valid` = `mem_resp_valid`.
  - `*_resp_rdata` = `mem_resp_rdata`, except for LSU stores, where it is 0.
  - When valid and ready are both high, go to IDLE.
  - The non-granted master sees resp_valid=0.
- Both `*_req_ready` are 0 outside IDLE, and the loser's ready is 0 in IDLE.
- **Default priority (macro off):** LSU always wins simultaneous requests.

## Timing
- **Reset values:**
  - state=IDLE, `gnt`=0, `last_gnt`=1.
  - Request registers are 0.
  - All `*_valid` and `*_ready` outputs are 0, except that `*_req_ready` may assert combinationally in IDLE.
  - `*_resp_rdata` is 0.
- **Latency with a zero-wait slave:** accept at cycle N, `mem_req_valid` at N+1. If the slave responds at N+2 and the master is ready, the response handshake completes at N+2. The next accept happens at N+3, so the minimum is 3 cycles per transaction.
- **Stalls:**
  - A slave stall in REQ holds the state indefinitely.
  - A master not ready in RESP backpressures the slave via `mem_resp_ready`=0.
- **Boundaries:**
  - A request that arrives while busy waits; it is never dropped.
  - A valid that drops in IDLE before being accepted is simply ignored.
  - Responses arriving in IDLE or REQ are not acknowledged (`mem_resp_ready`=0).
- **Reset mid-transaction:** everything returns to reset values immediately and the in-flight transaction is abandoned. The slave shares `rst`.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`:
  - **Defined:** a `last_gnt` register updates on every accept. On simultaneous requests the master not in `last_gnt` wins. A single requester always wins.
  - **Undefined:** fixed LSU priority; `last_gnt` is not built.

## Test plan
- **IFU alone:** IFU reads 0x8000_0000 and the slave returns 0x0000_0413 with zero wait.
  - `ifu_resp_rdata`=0x0000_0413 at cycle N+2.
  - `mem_req_wen`=0, `mem_req_wstrb`=4'hF.
  - `lsu_resp_valid` stays 0.
- **LSU store:** addr 0x8000_1000, wdata 0xDEAD_BEEF, wstrb 4'b0011, with a 3-cycle slave `mem_req_ready` stall.
  - The slave sees the same fields held for all 3 stall cycles.
  - `lsu_resp_valid` pulses with rdata=0.
  - `ifu_req_ready`=0 throughout.
- **Simultaneous requests, macro off:** IFU and LSU request together twice. LSU is granted both times and IFU is served third.
- **Simultaneous requests, `MEM_ARB_ROUND_ROBIN_EN`:** after reset, IFU is granted first. On the next simultaneous request LSU is granted, then IFU again.
- **Response backpressure:** `lsu_resp_ready` is held 0 for 2 cycles while `mem_resp_valid`=1.
  - `mem_resp_ready`=0 during those 2 cycles.
  - Completion happens on the cycle ready rises, and the state then returns to IDLE.
- **Reset in REQ:** assert `rst` asynchronously in REQ. `mem_req_valid` drops before the next clock edge, the state is IDLE after release, and a new IFU request is then accepted.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory slave port between instruction fetch (IFU)
// and data access (LSU). One transaction is in flight at a time and is
// handled in three phases: IDLE (arbitrate and latch), REQ (present the
// request to the slave) and RESP (route the response to the owner).
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN. When it is defined, a
// last_gnt register alternates the winner on simultaneous requests. When it
// is undefined, the LSU always wins simultaneous requests.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_req_addr,
   output logic                ifu_resp_valid,
   input  logic                ifu_resp_ready,
   output logic [DATA_W-1:0]   ifu_resp_rdata,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_req_addr,
   input  logic                lsu_req_wen,
   input  logic [DATA_W-1:0]   lsu_req_wdata,
   input  logic [DATA_W/8-1:0] lsu_req_wstrb,
   output logic                lsu_resp_valid,
   input  logic                lsu_resp_ready,
   output logic [DATA_W-1:0]   lsu_resp_rdata,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic                mem_req_wen,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_wstrb,
   input  logic                mem_resp_valid,
   output logic                mem_resp_ready,
   input  logic [DATA_W-1:0]   mem_resp_rdata
);
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              state_r;
   logic                gnt_r;            // 0 = IFU owns the port, 1 = LSU
   logic                mem_req_valid_r;
   logic [ADDR_W-1:0]   req_addr_r;
   logic                req_wen_r;
   logic [DATA_W-1:0]   req_wdata_r;
   logic [STRB_W-1:0]   req_wstrb_r;

   logic                in_idle_s;
   logic                in_resp_s;
   logic                any_req_s;
   logic                pick_lsu_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic                last_gnt_r;       // owner of the most recent accept
`endif

   // Decode the phase and pick a winner among the current requesters.
   always_comb begin
      in_idle_s = (state_r == ST_IDLE);
      in_resp_s = (state_r == ST_RESP);
      any_req_s = ifu_req_valid | lsu_req_valid;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (ifu_req_valid && lsu_req_valid) begin
         pick_lsu_s = ~last_gnt_r;        // the master not served last goes next
      end else begin
         pick_lsu_s = lsu_req_valid;      // a single requester always wins
      end
`else
      pick_lsu_s = lsu_req_valid;         // LSU has fixed priority
`endif
   end

   // Only the winner sees ready, and only in IDLE.
   always_comb begin
      ifu_req_ready = 1'b0;
      lsu_req_ready = 1'b0;
      if (in_idle_s && any_req_s) begin
         if (pick_lsu_s) begin
            lsu_req_ready = 1'b1;
         end else begin
            ifu_req_ready = 1'b1;
         end
      end else begin
         ifu_req_ready = 1'b0;
         lsu_req_ready = 1'b0;
      end
   end

   // Route the slave response to the owner. Store acknowledgements carry zero data.
   always_comb begin
      mem_resp_ready = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
      ifu_resp_rdata = {DATA_W{1'b0}};
      lsu_resp_rdata = {DATA_W{1'b0}};
      if (in_resp_s) begin
         if (gnt_r) begin
            mem_resp_ready = lsu_resp_ready;
            lsu_resp_valid = mem_resp_valid;
            if (req_wen_r) begin
               lsu_resp_rdata = {DATA_W{1'b0}};
            end else begin
               lsu_resp_rdata = mem_resp_rdata;
            end
         end else begin
            mem_resp_ready = ifu_resp_ready;
            ifu_resp_valid = mem_resp_valid;
            ifu_resp_rdata = mem_resp_rdata;
         end
      end else begin
         mem_resp_ready = 1'b0;
         ifu_resp_valid = 1'b0;
         lsu_resp_valid = 1'b0;
      end
   end

   // Transaction FSM: latch the winner's request, hold it through slave stalls,
   // and return to IDLE once the response handshake completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r         <= ST_IDLE;
         gnt_r           <= 1'b0;
         mem_req_valid_r <= 1'b0;
         req_addr_r      <= {ADDR_W{1'b0}};
         req_wen_r       <= 1'b0;
         req_wdata_r     <= {DATA_W{1'b0}};
         req_wstrb_r     <= {STRB_W{1'b0}};
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_gnt_r      <= 1'b1;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (any_req_s) begin
                  gnt_r           <= pick_lsu_s;
                  mem_req_valid_r <= 1'b1;
                  state_r         <= ST_REQ;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  last_gnt_r      <= pick_lsu_s;
`endif
                  if (pick_lsu_s) begin
                     req_addr_r  <= lsu_req_addr;
                     req_wen_r   <= lsu_req_wen;
                     req_wdata_r <= lsu_req_wdata;
                     req_wstrb_r <= lsu_req_wstrb;
                  end else begin
                     // Fetches are always full-word reads.
                     req_addr_r  <= ifu_req_addr;
                     req_wen_r   <= 1'b0;
                     req_wdata_r <= {DATA_W{1'b0}};
                     req_wstrb_r <= {STRB_W{1'b1}};
                  end
               end
            end
            ST_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid_r <= 1'b0;
                  state_r         <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (mem_resp_valid && mem_resp_ready) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               mem_req_valid_r <= 1'b0;
               state_r         <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_req_valid = mem_req_valid_r;
   assign mem_req_addr  = req_addr_r;
   assign mem_req_wen   = req_wen_r;
   assign mem_req_wdata = req_wdata_r;
   assign mem_req_wstrb = req_wstrb_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Expected slave-side
// requests are queued in predicted grant order when stimulus is queued.
// They are popped and compared when the slave handshake happens. A small
// reference model of the handshake rules is compared every cycle.
module tb_mem_arbiter;
   logic        clk;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready;
   logic [31:0] ifu_req_addr;
   logic        ifu_resp_valid, ifu_resp_ready;
   logic [31:0] ifu_resp_rdata;
   logic        lsu_req_valid, lsu_req_ready;
   logic [31:0] lsu_req_addr;
   logic        lsu_req_wen;
   logic [31:0] lsu_req_wdata;
   logic [3:0]  lsu_req_wstrb;
   logic        lsu_resp_valid, lsu_resp_ready;
   logic [31:0] lsu_resp_rdata;
   logic        mem_req_valid, mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_wen;
   logic [31:0] mem_req_wdata;
   logic [3:0]  mem_req_wstrb;
   logic        mem_resp_valid, mem_resp_ready;
   logic [31:0] mem_resp_rdata;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_req_addr(ifu_req_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
      .ifu_resp_rdata(ifu_resp_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
      .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
      .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
      .lsu_resp_rdata(lsu_resp_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
      .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
      .mem_resp_rdata(mem_resp_rdata)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } mreq_t;

   typedef struct packed {
      logic  who;      // 0 = IFU, 1 = LSU
      mreq_t r;
   } exp_t;

   logic [31:0] ifu_q[$];
   mreq_t       lsu_q[$];
   exp_t        exp_q[$];

   int          n_chk;
   int          n_pass;
   int          cyc;
   int          acc_cyc;
   int          stall_left;
   int          hold_left;
   int          cfg_stall;
   int          cfg_hold;
   logic        busy;
   logic        sl_have;
   logic        owner;
   logic        last_m;
   logic        spur;
   logic        chk_lat;
   logic [31:0] sl_data;
   logic [31:0] cur_rdata;

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h0000_0413;
      return a ^ 32'h5A5A_1234;
   endfunction

   task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic add_ifu(input logic [31:0] a);
      ifu_q.push_back(a);
   endtask

   task automatic add_lsu(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      mreq_t m;
      m.addr = a; m.wen = w; m.wdata = d; m.wstrb = s;
      lsu_q.push_back(m);
   endtask

   task automatic exp_ifu(input logic [31:0] a);
      exp_t e;
      e.who = 1'b0; e.r.addr = a; e.r.wen = 1'b0; e.r.wdata = 32'h0; e.r.wstrb = 4'hF;
      exp_q.push_back(e);
   endtask

   task automatic exp_lsu(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      exp_t e;
      e.who = 1'b1; e.r.addr = a; e.r.wen = w; e.r.wdata = d; e.r.wstrb = s;
      exp_q.push_back(e);
   endtask

   task automatic clear_model();
      ifu_q.delete(); lsu_q.delete(); exp_q.delete();
      busy = 1'b0; sl_have = 1'b0; owner = 1'b0; last_m = 1'b1;
      stall_left = 0; hold_left = 0; cfg_stall = 0; cfg_hold = 0;
      spur = 1'b0; chk_lat = 1'b0;
      ifu_req_valid = 1'b0; ifu_req_addr = 32'h0; ifu_resp_ready = 1'b0;
      lsu_req_valid = 1'b0; lsu_req_addr = 32'h0; lsu_req_wen = 1'b0;
      lsu_req_wdata = 32'h0; lsu_req_wstrb = 4'h0; lsu_resp_ready = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'h0;
   endtask

   // One clock: drive masters and slave at negedge, compare against the model, update.
   task automatic tick();
      logic lw, ihs, lhs, mqhs, mphs, irhs, lrhs;
      exp_t e;
      @(negedge clk);
      ifu_req_valid = (ifu_q.size() > 0);
      ifu_req_addr  = (ifu_q.size() > 0) ? ifu_q[0] : 32'h0;
      lsu_req_valid = (lsu_q.size() > 0);
      if (lsu_q.size() > 0) begin
         lsu_req_addr = lsu_q[0].addr; lsu_req_wen = lsu_q[0].wen;
         lsu_req_wdata = lsu_q[0].wdata; lsu_req_wstrb = lsu_q[0].wstrb;
      end
      mem_req_ready = 1'b0;
      if (mem_req_valid) begin
         if (stall_left > 0) begin
            stall_left--;
            if (exp_q.size() > 0)
               check_val("req_hold", 128'({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb}),
                         128'(exp_q[0].r));
         end else begin
            mem_req_ready = 1'b1;
         end
      end
      mem_resp_valid = sl_have | spur;
      mem_resp_rdata = sl_have ? sl_data : 32'hBAD0_0BAD;
      ifu_resp_ready = 1'b1;
      lsu_resp_ready = 1'b1;
      if (sl_have && owner && hold_left > 0) begin
         lsu_resp_ready = 1'b0;
         hold_left--;
      end
      #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      lw = lsu_req_valid && (!ifu_req_valid || !last_m);
`else
      lw = lsu_req_valid;
`endif
      check_val("ifu_req_ready", 128'(ifu_req_ready), 128'(!busy && ifu_req_valid && !lw));
      check_val("lsu_req_ready", 128'(lsu_req_ready), 128'(!busy && lw));
      check_val("mem_req_valid", 128'(mem_req_valid), 128'(busy && !sl_have));
      if (sl_have) begin
         check_val("mem_resp_ready", 128'(mem_resp_ready), 128'(owner ? lsu_resp_ready : ifu_resp_ready));
         check_val("ifu_resp_valid", 128'(ifu_resp_valid), 128'(!owner && mem_resp_valid));
         check_val("lsu_resp_valid", 128'(lsu_resp_valid), 128'(owner && mem_resp_valid));
      end else begin
         check_val("resp_idle", 128'({mem_resp_ready, ifu_resp_valid, lsu_resp_valid}), 128'(0));
      end
      ihs  = ifu_req_valid & ifu_req_ready;
      lhs  = lsu_req_valid & lsu_req_ready;
      mqhs = mem_req_valid & mem_req_ready;
      mphs = mem_resp_valid & mem_resp_ready;
      irhs = ifu_resp_valid & ifu_resp_ready;
      lrhs = lsu_resp_valid & lsu_resp_ready;
      if (mqhs) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_req", 128'(1), 128'(0));
         end else begin
            e = exp_q.pop_front();
            check_val("req_fields", 128'({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb}), 128'(e.r));
            owner     = e.who;
            sl_data   = mem_data(mem_req_addr);
            cur_rdata = e.r.wen ? 32'h0 : mem_data(e.r.addr);
            hold_left = cfg_hold;
            sl_have   = 1'b1;
         end
      end
      if (irhs) begin
         check_val("ifu_rdata", 128'(ifu_resp_rdata), 128'(cur_rdata));
         if (chk_lat) check_val("latency", 128'(cyc - acc_cyc), 128'(2));
      end
      if (lrhs) check_val("lsu_rdata", 128'(lsu_resp_rdata), 128'(cur_rdata));
      if (ihs) begin
         void'(ifu_q.pop_front()); busy = 1'b1; acc_cyc = cyc; stall_left = cfg_stall; last_m = 1'b0;
      end
      if (lhs) begin
         void'(lsu_q.pop_front()); busy = 1'b1; acc_cyc = cyc; stall_left = cfg_stall; last_m = 1'b1;
      end
      if (mphs) begin
         sl_have = 1'b0; busy = 1'b0;
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic run(input int max);
      int n;
      n = 0;
      while ((ifu_q.size() > 0 || lsu_q.size() > 0 || busy) && n < max) begin
         tick();
         n++;
      end
      if (n >= max) check_val("timeout", 128'(1), 128'(0));
      check_val("scoreboard_empty", 128'(exp_q.size()), 128'(0));
   endtask

   initial begin
      n_chk = 0; n_pass = 0; cyc = 0; acc_cyc = 0;
      sl_data = 32'h0; cur_rdata = 32'h0;
      clear_model();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_val("rst_ctrl", 128'({mem_req_valid, mem_resp_ready, ifu_req_ready, lsu_req_ready,
                                  ifu_resp_valid, lsu_resp_valid, ifu_resp_rdata, lsu_resp_rdata}), 128'(0));
      check_val("rst_req_regs", 128'({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb}), 128'(0));
      @(negedge clk);
      rst = 1'b0;

      // IFU alone, zero-wait slave.
      chk_lat = 1'b1;
      add_ifu(32'h8000_0000); exp_ifu(32'h8000_0000);
      run(20);
      chk_lat = 1'b0;

      // LSU store with a 3-cycle slave stall; an IFU fetch arrives while busy.
      cfg_stall = 3; spur = 1'b1;
      add_lsu(1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011);
      exp_lsu(1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011);
      tick();
      cfg_stall = 0;
      add_ifu(32'h8000_0004); exp_ifu(32'h8000_0004);
      run(40);
      spur = 1'b0;

      // Response backpressure on an LSU load, then a fetch.
      cfg_hold = 2;
      add_lsu(1'b0, 32'h8000_2000, 32'h1111_2222, 4'hF);
      exp_lsu(1'b0, 32'h8000_2000, 32'h1111_2222, 4'hF);
      add_ifu(32'h8000_0008); exp_ifu(32'h8000_0008);
      run(40);
      cfg_hold = 0;

      // Reset while the slave stalls in REQ.
      cfg_stall = 100; spur = 1'b1;
      add_ifu(32'h8000_0040); exp_ifu(32'h8000_0040);
      repeat (4) tick();
      #2;
      rst = 1'b1;
      #1;
      check_val("rst_async_valid", 128'(mem_req_valid), 128'(0));
      check_val("rst_async_regs", 128'({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb}), 128'(0));
      clear_model();
      @(negedge clk);
      rst = 1'b0;

      // Simultaneous requests straight after reset.
`ifdef MEM_ARB_ROUND_ROBIN_EN
      add_ifu(32'h8000_0100); add_ifu(32'h8000_0104);
      add_lsu(1'b0, 32'h8000_3000, 32'h0, 4'hF);
      exp_ifu(32'h8000_0100);
      exp_lsu(1'b0, 32'h8000_3000, 32'h0, 4'hF);
      exp_ifu(32'h8000_0104);
`else
      add_lsu(1'b0, 32'h8000_3000, 32'h0, 4'hF);
      add_lsu(1'b1, 32'h8000_3004, 32'hCAFE_F00D, 4'b1100);
      add_ifu(32'h8000_0000);
      exp_lsu(1'b0, 32'h8000_3000, 32'h0, 4'hF);
      exp_lsu(1'b1, 32'h8000_3004, 32'hCAFE_F00D, 4'b1100);
      exp_ifu(32'h8000_0000);
`endif
      run(60);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
